// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_if
//  Description : MEM->WB pipeline bus and register-file write port.
//                Forwarding signals exist only when WB_FORWARD_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_stage_if #(
    parameter int DATA_LENGTH     = 32,
    parameter int REG_ADDR_LENGTH = 5
);
    logic                       inValid;
    logic                       inReady;
    logic                       stall;
    logic                       flush;
    logic [DATA_LENGTH-1:0]     pcIn;
    logic [DATA_LENGTH-1:0]     aluIn;
    logic [DATA_LENGTH-1:0]     memIn;
    logic [REG_ADDR_LENGTH-1:0] rdIn;
    logic                       wenIn;
    logic [1:0]                 WBSel;
    logic [2:0]                 funct3;
    logic                       RegWEn;
    logic [REG_ADDR_LENGTH-1:0] addrD;
    logic [DATA_LENGTH-1:0]     dataD;
    logic [63:0]                instret;
`ifdef WB_FORWARD_EN
    logic [REG_ADDR_LENGTH-1:0] rs1Addr;
    logic [REG_ADDR_LENGTH-1:0] rs2Addr;
    logic                       fwdA;
    logic                       fwdB;
    logic [DATA_LENGTH-1:0]     fwdData;
`endif

    modport master (
        output inValid, stall, flush, pcIn, aluIn, memIn, rdIn, wenIn, WBSel, funct3,
`ifdef WB_FORWARD_EN
        output rs1Addr, rs2Addr,
        input  fwdA, fwdB, fwdData,
`endif
        input  inReady, RegWEn, addrD, dataD, instret
    );

    modport slave (
        input  inValid, stall, flush, pcIn, aluIn, memIn, rdIn, wenIn, WBSel, funct3,
`ifdef WB_FORWARD_EN
        input  rs1Addr, rs2Addr,
        output fwdA, fwdB, fwdData,
`endif
        output inReady, RegWEn, addrD, dataD, instret
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Writeback stage: one pipeline register, load extraction,
//                writeback mux and retired-instruction counter.
//                Optional macro WB_FORWARD_EN adds WB->EX forwarding outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_LENGTH     = 32,
    parameter int REG_ADDR_LENGTH = 5
) (
    input  wire logic clk,
    input  wire logic rst_n,
    wb_stage_if.slave bus
);
    localparam logic [1:0] c_WB_MEM = 2'b00;
    localparam logic [1:0] c_WB_PC4 = 2'b10;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    logic                       r_valid;
    logic [DATA_LENGTH-1:0]     r_pc;
    logic [DATA_LENGTH-1:0]     r_alu;
    logic [DATA_LENGTH-1:0]     r_mem;
    logic [REG_ADDR_LENGTH-1:0] r_rd;
    logic                       r_wen;
    logic [1:0]                 r_wbSel;
    logic [2:0]                 r_funct3;
    logic [63:0]                r_instret;

    logic                       w_regWEn;
    logic [7:0]                 w_byte;
    logic [15:0]                w_half;
    logic [DATA_LENGTH-1:0]     w_loadData;
    logic [DATA_LENGTH-1:0]     w_dataD;

    // Flush wins over stall and capture; fields are only loaded with a real instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_alu     <= '0;
            r_mem     <= '0;
            r_rd      <= '0;
            r_wen     <= 1'b0;
            r_wbSel   <= 2'b00;
            r_funct3  <= 3'b000;
            r_instret <= 64'd0;
        end else begin
            if (r_valid && !bus.stall) begin
                r_instret <= r_instret + 64'd1;
            end
            if (bus.flush) begin
                r_valid <= 1'b0;
            end else if (!bus.stall) begin
                r_valid <= bus.inValid;
                if (bus.inValid) begin
                    r_pc     <= bus.pcIn;
                    r_alu    <= bus.aluIn;
                    r_mem    <= bus.memIn;
                    r_rd     <= bus.rdIn;
                    r_wen    <= bus.wenIn;
                    r_wbSel  <= bus.WBSel;
                    r_funct3 <= bus.funct3;
                end
            end
        end
    end

    always_comb begin
        w_byte = r_mem[7:0];
        case (r_alu[1:0])
            2'd0:    w_byte = r_mem[7:0];
            2'd1:    w_byte = r_mem[15:8];
            2'd2:    w_byte = r_mem[23:16];
            default: w_byte = r_mem[31:24];
        endcase
    end

    assign w_half = r_alu[1] ? r_mem[31:16] : r_mem[15:0];

    // Reserved size codes fall through to a full-word load.
    always_comb begin
        w_loadData = r_mem;
        case (r_funct3)
            c_F3_LB:  w_loadData = {{(DATA_LENGTH-8){w_byte[7]}}, w_byte};
            c_F3_LH:  w_loadData = {{(DATA_LENGTH-16){w_half[15]}}, w_half};
            c_F3_LBU: w_loadData = {{(DATA_LENGTH-8){1'b0}}, w_byte};
            c_F3_LHU: w_loadData = {{(DATA_LENGTH-16){1'b0}}, w_half};
            default:  w_loadData = r_mem;
        endcase
    end

    always_comb begin
        w_dataD = r_alu;
        case (r_wbSel)
            c_WB_MEM: w_dataD = w_loadData;
            c_WB_PC4: w_dataD = r_pc + DATA_LENGTH'(4);
            default:  w_dataD = r_alu;
        endcase
    end

    // x0 is hardwired zero, so a write to it is never issued.
    assign w_regWEn    = r_valid && r_wen && (r_rd != '0) && !bus.stall;

    assign bus.inReady = !bus.stall;
    assign bus.RegWEn  = w_regWEn;
    assign bus.addrD   = r_rd;
    assign bus.dataD   = w_dataD;
    assign bus.instret = r_instret;

`ifdef WB_FORWARD_EN
    assign bus.fwdA    = w_regWEn && (bus.rs1Addr == r_rd);
    assign bus.fwdB    = w_regWEn && (bus.rs2Addr == r_rd);
    assign bus.fwdData = w_dataD;
`endif
endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage: directed cases then random
//                traffic against a behavioural model of the stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_stage;
    localparam int DL = 32;
    localparam int AL = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wb_stage_if #(.DATA_LENGTH(DL), .REG_ADDR_LENGTH(AL)) wb ();

    wb_stage #(.DATA_LENGTH(DL), .REG_ADDR_LENGTH(AL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction held in the writeback register.
    bit                 mV;
    int unsigned        mPc, mAlu, mMem;
    int unsigned        mRd;
    bit                 mWen;
    int unsigned        mSel, mF3;
    longint unsigned    mCnt;

    function automatic int unsigned loadValue();
        int unsigned lane, b, h;
        lane = mAlu % 4;
        b = (mMem >> (8 * lane)) % 256;
        h = ((mAlu % 4) >= 2) ? (mMem >> 16) : (mMem % 65536);
        case (mF3)
            0:       return (b < 128)   ? b : b - 256;
            1:       return (h < 32768) ? h : h - 65536;
            4:       return b;
            5:       return h;
            default: return mMem;
        endcase
    endfunction

    function automatic int unsigned expData();
        if (mSel == 0) return loadValue();
        if (mSel == 2) return mPc + 4;
        return mAlu;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the pre-edge outputs, then advance the model.
    task automatic step(input bit v, input bit s, input bit f, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd,
                        input bit wen, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        bit expWe;
        wb.inValid = v;  wb.stall = s;   wb.flush = f;
        wb.pcIn = pc;    wb.aluIn = alu; wb.memIn = mem;
        wb.rdIn = rd;    wb.wenIn = wen; wb.WBSel = sel; wb.funct3 = f3;
`ifdef WB_FORWARD_EN
        wb.rs1Addr = rs1; wb.rs2Addr = rs2;
`endif
        #1;
        expWe = mV && mWen && (mRd != 0) && !s;
        chk("inReady", wb.inReady, !s);
        chk("RegWEn",  wb.RegWEn,  expWe);
        chk("addrD",   wb.addrD,   mRd);
        chk("dataD",   wb.dataD,   expData());
        chk("instret", wb.instret, mCnt);
`ifdef WB_FORWARD_EN
        chk("fwdA",    wb.fwdA,    expWe && (rs1 == mRd));
        chk("fwdB",    wb.fwdB,    expWe && (rs2 == mRd));
        chk("fwdData", wb.fwdData, expData());
`endif
        @(posedge clk);
        if (mV && !s) mCnt++;
        if (f) mV = 0;
        else if (!s) begin
            mV = v;
            if (v) begin
                mPc = pc; mAlu = alu; mMem = mem; mRd = rd;
                mWen = wen; mSel = sel; mF3 = f3;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
    task automatic doReset();
        rst_n = 1'b0;
        wb.inValid = 0; wb.stall = 0; wb.flush = 0;
        #2;
        mV = 0; mPc = 0; mAlu = 0; mMem = 0; mRd = 0; mWen = 0; mSel = 0; mF3 = 0; mCnt = 0;
        chk("rst_RegWEn",  wb.RegWEn,  1'b0);
        chk("rst_addrD",   wb.addrD,   5'd0);
        chk("rst_dataD",   wb.dataD,   32'd0);
        chk("rst_instret", wb.instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    longint unsigned cnt0;

    initial begin
        checks = 0;
        errors = 0;
        wb.inValid = 0; wb.stall = 0; wb.flush = 0;
        wb.pcIn = 0; wb.aluIn = 0; wb.memIn = 0; wb.rdIn = 0;
        wb.wenIn = 0; wb.WBSel = 0; wb.funct3 = 0;
`ifdef WB_FORWARD_EN
        wb.rs1Addr = 0; wb.rs2Addr = 0;
`endif
        rst_n = 1'b0;
        #7;
        doReset();

        // LB / LBU on byte lane 2 holding 0xFF
        step(1, 0, 0, 32'h0, 32'h1000_0002, 32'h80FF_7F01, 5, 1, 2'b00, 3'b000, 0, 0);
        chk("LB_we", wb.RegWEn, 1'b1);
        chk("LB_rd", wb.addrD, 5'd5);
        chk("LB_data", wb.dataD, 32'hFFFF_FFFF);
        step(1, 0, 0, 32'h0, 32'h1000_0002, 32'h80FF_7F01, 5, 1, 2'b00, 3'b100, 0, 0);
        chk("LBU_data", wb.dataD, 32'h0000_00FF);
        step(1, 0, 0, 32'h0, 32'h0000_0002, 32'h8000_1234, 9, 1, 2'b00, 3'b001, 0, 0);
        chk("LH_data", wb.dataD, 32'hFFFF_8000);
        step(1, 0, 0, 32'h100, 32'h0, 32'h0, 1, 1, 2'b10, 3'b000, 0, 0);
        chk("JAL_data", wb.dataD, 32'h104);
        step(1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1, 1, 2'b10, 3'b000, 0, 0);
        chk("PC4_wrap", wb.dataD, 32'h0);

        // Write to x0 is suppressed but still retires
        step(1, 0, 0, 32'h0, 32'h1234, 32'h0, 0, 1, 2'b01, 3'b000, 0, 0);
        chk("x0_we", wb.RegWEn, 1'b0);
        cnt0 = mCnt;
        idle();
        chk("x0_count", wb.instret, cnt0 + 1);

        // Three-cycle stall holds the instruction; one write after release
        step(1, 0, 0, 32'h0, 32'hABCD, 32'h0, 3, 1, 2'b11, 3'b000, 0, 0);
        cnt0 = mCnt;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 32'h0, 32'h5555, 32'h0, 4, 1, 2'b01, 3'b000, 0, 0);
            chk("stall_hold", wb.dataD, 32'hABCD);
        end
        chk("stall_count", wb.instret, cnt0);
        idle();
        chk("release_count", wb.instret, cnt0 + 1);
        chk("release_bubble", wb.RegWEn, 1'b0);

        // Flush during stall kills without counting
        step(1, 0, 0, 32'h0, 32'h77, 32'h0, 6, 1, 2'b01, 3'b000, 0, 0);
        cnt0 = mCnt;
        step(0, 1, 1, 32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 3'b000, 0, 0);
        chk("flush_we", wb.RegWEn, 1'b0);
        idle();
        chk("flush_count", wb.instret, cnt0);

        // Reset pulse while stalled with a live instruction
        step(1, 0, 0, 32'h0, 32'h99, 32'h0, 8, 1, 2'b01, 3'b000, 0, 0);
        step(0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 3'b000, 0, 0);
        doReset();
        idle();
        chk("post_rst_count", wb.instret, 64'd0);

`ifdef WB_FORWARD_EN
        step(1, 0, 0, 32'h0, 32'h55, 32'h0, 7, 1, 2'b01, 3'b000, 7, 0);
        wb.rs1Addr = 7; wb.rs2Addr = 0;
        #1;
        chk("fwdA_dir", wb.fwdA, 1'b1);
        chk("fwdB_dir", wb.fwdB, 1'b0);
        chk("fwdData_dir", wb.fwdData, 32'h55);
`endif

        // Random traffic; every step is checked against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 (i % 50 == 0) ? 32'hFFFF_FFFC : $urandom, a, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom), 3'($urandom),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
